perceptron_update_scheduler: RTL and testbench
==============================================

Name: perceptron_update_scheduler

Overview:
Arbitrates the single-ported perceptron weight table between front-end prediction lookups and back-end training updates. Feedback from branch resolution is buffered in a small FIFO. Each buffered entry is drained as a 2-cycle read-modify-write: UPD_RD fetches the row, UPD_WR writes it back. Lookups have priority, and a starvation counter forces an update through when lookups hog the port. The block sits between the fetch/EX feedback paths and the weight-table storage.

Parameters:
ADDR_WIDTH, 32, PC width
INDEX_BITS, 10, log2 of perceptron count (1024 rows)
FIFO_DEPTH, 4, feedback entries buffered; power of two, >=2
STARVE_LIMIT, 8, consecutive lookup-granted cycles with a non-empty FIFO before an update is forced

Ports:
clk  in  1  clock
rst_n  in  1  synchronous reset, active-low
i_req_valid  in  1  prediction lookup request
i_req_pc  in  ADDR_WIDTH  lookup PC
o_req_stall  out  1  lookup not served this cycle; requester holds and re-presents
i_fb_valid  in  1  resolved-branch feedback
i_fb_pc  in  ADDR_WIDTH  resolved PC
i_fb_outcome  in  1  1=TAKEN
i_fb_mispredict  in  1  prediction was wrong
o_fb_full  out  1  FIFO full; feedback presented this cycle is dropped
o_tbl_en  out  1  table port active
o_tbl_we  out  1  write strobe (UPD_WR only)
o_tbl_index  out  INDEX_BITS  row index
o_tbl_outcome  out  1  training direction for write
o_tbl_force  out  1  train even if |sum|>threshold (= mispredict)

Behaviour:
- Index for both lookups and feedback is pc[INDEX_BITS+1:2]. It is computed at request/enqueue time.
- Reset state: FIFO empty, FSM IDLE, starve counter 0.
- Outputs in reset: o_tbl_en=0, o_tbl_we=0, o_tbl_index=0, o_req_stall=0, o_fb_full=0.
- FSM states: IDLE, UPD_RD, UPD_WR.
- IDLE:
  - If i_req_valid and starve count < STARVE_LIMIT, grant the lookup: o_tbl_en=1, o_tbl_we=0, index from i_req_pc, o_req_stall=0.
  - If the FIFO is non-empty and the lookup is granted, starve count increments, saturating at STARVE_LIMIT.
  - Else if the FIFO is non-empty, go to UPD_RD. o_req_stall equals i_req_valid that cycle.
  - The starve counter clears whenever an update starts or the FIFO is empty.
- UPD_RD: o_tbl_en=1, o_tbl_we=0, index=FIFO head. Always go to UPD_WR next cycle. o_req_stall=i_req_valid.
- UPD_WR: o_tbl_en=1, o_tbl_we=1, index/outcome/force from FIFO head. Pop the head and return to IDLE. o_req_stall=i_req_valid.
- All o_tbl_* outputs are combinational from state and FIFO head; the table samples them at the posedge.
- FIFO:
  - Push when i_fb_valid and not full.
  - Full: feedback is dropped silently and the FIFO is unchanged. o_fb_full=(count==FIFO_DEPTH), combinational.
  - A simultaneous push and pop at full is not permitted: full is evaluated before the pop, so that push is dropped.
  - Push and pop on the same cycle when not full: count is unchanged and both pointers advance.
  - Pointers wrap modulo FIFO_DEPTH. Count width is $clog2(FIFO_DEPTH)+1.
- The head entry is stable from UPD_RD through UPD_WR; pushes never alter it.
- Same-row hazard: if a lookup index equals the FIFO head index in IDLE, the lookup is still granted and reads the pre-update row (stale by design).
- Reset asserted mid-RMW (UPD_RD or UPD_WR): next cycle is IDLE with the FIFO flushed. No write issues in the reset cycle (o_tbl_we=0).

Optional Feature:
- Macro: PERCEPTRON_SCHED_STATS_EN.
- When defined, the block adds three 32-bit outputs:
  - o_stat_drops: feedback dropped on full
  - o_stat_stalls: cycles with i_req_valid && o_req_stall
  - o_stat_forced: updates started because starve count hit STARVE_LIMIT
- Counters are saturating, zero on reset, and update at posedge.
- When undefined, these ports and counters do not exist; behaviour is otherwise identical.

Decomposition:
- Shared package mips_core_pkg gains:
  - enum SchedState {IDLE, UPD_RD, UPD_WR}
  - struct FbEntry {index, outcome, force}
- Sub-module fb_fifo (parameterized depth/type): push/pop/full/empty/head/count. The scheduler FSM and starve counter stay in the top module.

Test Plan:
1. After reset, i_req_valid=1 every cycle with no feedback: o_req_stall=0 always; o_tbl_index tracks pc[11:2]; o_tbl_we never 1.
2. Single feedback (pc=0x0040_0010, outcome=1, mispredict=1) with no lookups: UPD_RD at index 4 next cycle, then UPD_WR with we=1, outcome=1, force=1; FIFO empty after.
3. Continuous lookups plus one feedback: exactly 8 lookups granted, then forced UPD_RD/UPD_WR with o_req_stall=1 for 2 cycles; then lookups resume.
4. 5 feedbacks on consecutive cycles while lookups are starving updates (depth 4): o_fb_full=1 on the 5th and that entry is dropped; drained order equals the first 4.
5. Feedback arrives in the same cycle as an in-flight UPD_WR pop at count=2: count stays 2 and the entries retain order.
6. rst_n=0 during UPD_RD with 3 queued entries: next cycle IDLE, FIFO empty, no write strobe; with STATS_EN, all counters read 0.

Source files
------------

// File: rtl/mips_core_pkg.sv
// -----------------------------------------------------------------------------
// mips_core_pkg
//   Shared types for the perceptron predictor back end.
//   - SCHED_INDEX_BITS : row-index width of the perceptron weight table
//   - SchedState       : update scheduler FSM states
//   - FbEntry          : one buffered training request (row, direction, force)
// -----------------------------------------------------------------------------
package mips_core_pkg;

   localparam int unsigned SCHED_INDEX_BITS = 10;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      UPD_RD = 2'd1,
      UPD_WR = 2'd2
   } SchedState;

   // force_train: train even when |sum| exceeds the threshold (set on mispredict)
   typedef struct packed {
      logic [SCHED_INDEX_BITS-1:0] index;
      logic                        outcome;
      logic                        force_train;
   } FbEntry;

endpackage

// File: rtl/perceptron_update_scheduler_fb_fifo.sv
// -----------------------------------------------------------------------------
// fb_fifo
//   Small synchronous FIFO buffering resolved-branch feedback entries.
//   Ports:
//     clk, rst_n     : clock, synchronous active-low reset (flushes pointers)
//     push, din      : write request and data; ignored while full
//     pop            : remove head entry; ignored while empty
//     head           : current head entry (combinational read)
//     full, empty    : occupancy flags
//     count          : number of stored entries
//   Full is evaluated before the pop of the same cycle, so a push at full is
//   dropped even if the head is being popped.
// -----------------------------------------------------------------------------
module fb_fifo
   import mips_core_pkg::*;
#(
   parameter  int unsigned DEPTH = 4,
   parameter  type         T     = FbEntry,
   localparam int unsigned PTR_W = $clog2(DEPTH),
   localparam int unsigned CNT_W = $clog2(DEPTH) + 1
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             push,
   input  T                 din,
   input  logic             pop,
   output T                 head,
   output logic             full,
   output logic             empty,
   output logic [CNT_W-1:0] count
);

   localparam logic [CNT_W-1:0] DEPTH_CNT = CNT_W'(DEPTH);

   T                 mem [DEPTH];
   logic [PTR_W-1:0] rd_ptr;
   logic [PTR_W-1:0] wr_ptr;
   logic             do_push;
   logic             do_pop;

   assign full    = (count == DEPTH_CNT);
   assign empty   = (count == '0);
   assign do_push = push && !full;
   assign do_pop  = pop && !empty;
   assign head    = mem[rd_ptr];

   // Pointers wrap naturally because DEPTH is a power of two.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         rd_ptr <= '0;
         wr_ptr <= '0;
         count  <= '0;
      end else begin
         if (do_push) wr_ptr <= wr_ptr + PTR_W'(1);
         if (do_pop)  rd_ptr <= rd_ptr + PTR_W'(1);
         case ({do_push, do_pop})
            2'b10:   count <= count + CNT_W'(1);
            2'b01:   count <= count - CNT_W'(1);
            default: count <= count;
         endcase
      end
   end

   // Storage is not reset; stale contents are unreachable once pointers clear.
   always_ff @(posedge clk) begin
      if (do_push) mem[wr_ptr] <= din;
   end

endmodule

// File: rtl/perceptron_update_scheduler.sv
// -----------------------------------------------------------------------------
// perceptron_update_scheduler
//   Arbitrates the single-ported perceptron weight table between front-end
//   lookups and back-end training updates. Feedback is buffered in fb_fifo and
//   each entry is drained as a two-cycle read-modify-write (UPD_RD, UPD_WR).
//   Lookups win the port unless STARVE_LIMIT consecutive lookups have been
//   granted while feedback was waiting, in which case an update is forced.
//
//   Ports:
//     clk, rst_n        : clock, synchronous active-low reset
//     i_req_valid/pc    : lookup request; o_req_stall=1 means re-present
//     i_fb_*            : resolved-branch feedback; dropped while o_fb_full
//     o_tbl_en/we       : table port enable / write strobe (UPD_WR only)
//     o_tbl_index       : row index (lookup pc or FIFO head)
//     o_tbl_outcome     : training direction on write
//     o_tbl_force       : train regardless of threshold (mispredict)
//
//   Optional build macro PERCEPTRON_SCHED_STATS_EN adds saturating counters:
//     o_stat_drops  : feedback dropped because the FIFO was full
//     o_stat_stalls : cycles with i_req_valid && o_req_stall
//     o_stat_forced : updates started because the starve limit was reached
//
//   INDEX_BITS must match SCHED_INDEX_BITS, the row width of FbEntry.
// -----------------------------------------------------------------------------
module perceptron_update_scheduler
   import mips_core_pkg::*;
#(
   parameter int unsigned ADDR_WIDTH   = 32,
   parameter int unsigned INDEX_BITS   = SCHED_INDEX_BITS,
   parameter int unsigned FIFO_DEPTH   = 4,
   parameter int unsigned STARVE_LIMIT = 8
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  i_req_valid,
   input  logic [ADDR_WIDTH-1:0] i_req_pc,
   output logic                  o_req_stall,
   input  logic                  i_fb_valid,
   input  logic [ADDR_WIDTH-1:0] i_fb_pc,
   input  logic                  i_fb_outcome,
   input  logic                  i_fb_mispredict,
   output logic                  o_fb_full,
   output logic                  o_tbl_en,
   output logic                  o_tbl_we,
   output logic [INDEX_BITS-1:0] o_tbl_index,
   output logic                  o_tbl_outcome,
   output logic                  o_tbl_force
`ifdef PERCEPTRON_SCHED_STATS_EN
   ,
   output logic [31:0]           o_stat_drops,
   output logic [31:0]           o_stat_stalls,
   output logic [31:0]           o_stat_forced
`endif
);

   localparam int unsigned      SW         = $clog2(STARVE_LIMIT + 1);
   localparam int unsigned      CNT_W      = $clog2(FIFO_DEPTH) + 1;
   localparam logic [SW-1:0]    STARVE_MAX = SW'(STARVE_LIMIT);

   function automatic logic [SW-1:0] starve_sat_inc(input logic [SW-1:0] v);
      return (v >= STARVE_MAX) ? STARVE_MAX : v + SW'(1);
   endfunction

   function automatic logic [31:0] stat_sat_inc(input logic [31:0] v);
      return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
   endfunction

   SchedState        state;
   SchedState        state_nxt;
   logic [SW-1:0]    starve_cnt;
   logic             grant;
   logic             upd_start;
   logic             fifo_pop;
   logic             fifo_push;
   logic             fifo_full;
   logic             fifo_empty;
   logic [CNT_W-1:0] fifo_count;
   FbEntry           fifo_head;
   FbEntry           fb_entry;
   logic [INDEX_BITS-1:0] req_index;

   // Row index is taken from the word-aligned PC at request/enqueue time.
   assign req_index            = i_req_pc[INDEX_BITS+1:2];
   assign fb_entry.index       = i_fb_pc[INDEX_BITS+1:2];
   assign fb_entry.outcome     = i_fb_outcome;
   assign fb_entry.force_train = i_fb_mispredict;

   assign fifo_push = i_fb_valid && rst_n;
   assign o_fb_full = fifo_full && rst_n;

   fb_fifo #(
      .DEPTH (FIFO_DEPTH),
      .T     (FbEntry)
   ) u_fb_fifo (
      .clk   (clk),
      .rst_n (rst_n),
      .push  (fifo_push),
      .din   (fb_entry),
      .pop   (fifo_pop),
      .head  (fifo_head),
      .full  (fifo_full),
      .empty (fifo_empty),
      .count (fifo_count)
   );

   assign grant = (state == IDLE) && i_req_valid && (starve_cnt < STARVE_MAX);

   always_comb begin
      state_nxt     = state;
      o_tbl_en      = 1'b0;
      o_tbl_we      = 1'b0;
      o_tbl_index   = '0;
      o_tbl_outcome = 1'b0;
      o_tbl_force   = 1'b0;
      o_req_stall   = 1'b0;
      fifo_pop      = 1'b0;
      upd_start     = 1'b0;
      case (state)
         IDLE: begin
            if (grant) begin
               o_tbl_en    = 1'b1;
               o_tbl_index = req_index;
            end else if (!fifo_empty) begin
               state_nxt   = UPD_RD;
               upd_start   = 1'b1;
               o_req_stall = i_req_valid;
            end
         end
         UPD_RD: begin
            o_tbl_en    = 1'b1;
            o_tbl_index = fifo_head.index;
            o_req_stall = i_req_valid;
            state_nxt   = UPD_WR;
         end
         UPD_WR: begin
            o_tbl_en      = 1'b1;
            o_tbl_we      = 1'b1;
            o_tbl_index   = fifo_head.index;
            o_tbl_outcome = fifo_head.outcome;
            o_tbl_force   = fifo_head.force_train;
            o_req_stall   = i_req_valid;
            fifo_pop      = 1'b1;
            state_nxt     = IDLE;
         end
         default: state_nxt = IDLE;
      endcase
      // Reset overrides everything: the table port is idle and nothing pops.
      if (!rst_n) begin
         state_nxt     = IDLE;
         o_tbl_en      = 1'b0;
         o_tbl_we      = 1'b0;
         o_tbl_index   = '0;
         o_tbl_outcome = 1'b0;
         o_tbl_force   = 1'b0;
         o_req_stall   = 1'b0;
         fifo_pop      = 1'b0;
         upd_start     = 1'b0;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) state <= IDLE;
      else        state <= state_nxt;
   end

   // Counts lookups granted while feedback waits; cleared once an update
   // starts or nothing is queued.
   always_ff @(posedge clk) begin
      if (!rst_n)                       starve_cnt <= '0;
      else if (fifo_empty || upd_start) starve_cnt <= '0;
      else if (grant)                   starve_cnt <= starve_sat_inc(starve_cnt);
   end

`ifdef PERCEPTRON_SCHED_STATS_EN
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         o_stat_drops  <= '0;
         o_stat_stalls <= '0;
         o_stat_forced <= '0;
      end else begin
         if (i_fb_valid && fifo_full)
            o_stat_drops <= stat_sat_inc(o_stat_drops);
         if (i_req_valid && o_req_stall)
            o_stat_stalls <= stat_sat_inc(o_stat_stalls);
         if (upd_start && (starve_cnt == STARVE_MAX))
            o_stat_forced <= stat_sat_inc(o_stat_forced);
      end
   end
`endif

   logic unused_bits;
   assign unused_bits = ^{i_req_pc[ADDR_WIDTH-1:INDEX_BITS+2], i_req_pc[1:0],
                          i_fb_pc[ADDR_WIDTH-1:INDEX_BITS+2], i_fb_pc[1:0],
                          fifo_count};

endmodule

// File: tb/tb_perceptron_update_scheduler.sv
module tb_perceptron_update_scheduler;
   localparam int DEPTH = 4;
   localparam int LIMIT = 8;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        i_req_valid = 1'b0;
   logic [31:0] i_req_pc = '0;
   logic        o_req_stall;
   logic        i_fb_valid = 1'b0;
   logic [31:0] i_fb_pc = '0;
   logic        i_fb_outcome = 1'b0;
   logic        i_fb_mispredict = 1'b0;
   logic        o_fb_full;
   logic        o_tbl_en;
   logic        o_tbl_we;
   logic [9:0]  o_tbl_index;
   logic        o_tbl_outcome;
   logic        o_tbl_force;
`ifdef PERCEPTRON_SCHED_STATS_EN
   logic [31:0] o_stat_drops;
   logic [31:0] o_stat_stalls;
   logic [31:0] o_stat_forced;
`endif

   always #5 clk = ~clk;

   perceptron_update_scheduler #(
      .ADDR_WIDTH(32), .INDEX_BITS(10), .FIFO_DEPTH(DEPTH), .STARVE_LIMIT(LIMIT)
   ) dut (
      .clk(clk), .rst_n(rst_n),
      .i_req_valid(i_req_valid), .i_req_pc(i_req_pc), .o_req_stall(o_req_stall),
      .i_fb_valid(i_fb_valid), .i_fb_pc(i_fb_pc), .i_fb_outcome(i_fb_outcome),
      .i_fb_mispredict(i_fb_mispredict), .o_fb_full(o_fb_full),
      .o_tbl_en(o_tbl_en), .o_tbl_we(o_tbl_we), .o_tbl_index(o_tbl_index),
      .o_tbl_outcome(o_tbl_outcome), .o_tbl_force(o_tbl_force)
`ifdef PERCEPTRON_SCHED_STATS_EN
      , .o_stat_drops(o_stat_drops), .o_stat_stalls(o_stat_stalls),
      .o_stat_forced(o_stat_forced)
`endif
   );

   // Expected table accesses (pushed by the driver, popped when o_tbl_en)
   typedef struct { int cyc; bit we; int idx; bit outc; bit frc; } tx_t;
   // Expected per-cycle handshake outputs
   typedef struct { int cyc; bit stall; bit full; bit rst; } hs_t;
   typedef struct { int idx; bit outc; bit frc; } ent_t;

   tx_t  tx_q[$];
   hs_t  hs_q[$];
   ent_t m_q[$];      // pending training requests, in arrival order
   int   m_starve;    // lookups granted while training waits
   int   m_phase;     // 0: free, 1: row read of head, 2: row write of head
   int   m_drops, m_stalls, m_forced;
   int   cyc = 0;
   int   checks = 0;
   int   errors = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s at cycle %0d: got %0h expected %0h", name, cyc, act, exp);
      end
   endtask

   function automatic int row_of(input logic [31:0] pc);
      return int'((pc >> 2) & 32'h3FF);
   endfunction

   // One clock of stimulus; the reference model advances alongside it.
   task automatic step(input bit r, input bit rq, input logic [31:0] rpc,
                       input bit fv, input logic [31:0] fpc, input bit fo, input bit fm);
      bit   full, stall;
      ent_t e;
      @(posedge clk); #1;
`ifdef PERCEPTRON_SCHED_STATS_EN
      if (cyc > 0) begin
         chk("stat_drops", o_stat_drops, m_drops);
         chk("stat_stalls", o_stat_stalls, m_stalls);
         chk("stat_forced", o_stat_forced, m_forced);
      end
`endif
      rst_n = r; i_req_valid = rq; i_req_pc = rpc;
      i_fb_valid = fv; i_fb_pc = fpc; i_fb_outcome = fo; i_fb_mispredict = fm;
      cyc++;
      if (!r) begin
         hs_q.push_back('{cyc, 1'b0, 1'b0, 1'b1});
         m_q.delete(); m_starve = 0; m_phase = 0;
         m_drops = 0; m_stalls = 0; m_forced = 0;
         return;
      end
      full  = (m_q.size() == DEPTH);
      stall = 1'b0;
      if (m_phase == 0) begin
         if (rq && m_starve < LIMIT) begin
            tx_q.push_back('{cyc, 1'b0, row_of(rpc), 1'b0, 1'b0});
            if (m_q.size() > 0) m_starve = (m_starve + 1 > LIMIT) ? LIMIT : m_starve + 1;
            else m_starve = 0;
         end else if (m_q.size() > 0) begin
            stall = rq;
            if (m_starve == LIMIT) m_forced++;
            m_starve = 0;
            m_phase  = 1;
         end else m_starve = 0;
      end else if (m_phase == 1) begin
         tx_q.push_back('{cyc, 1'b0, m_q[0].idx, 1'b0, 1'b0});
         stall   = rq;
         m_phase = 2;
      end else begin
         tx_q.push_back('{cyc, 1'b1, m_q[0].idx, m_q[0].outc, m_q[0].frc});
         stall = rq;
         void'(m_q.pop_front());
         m_phase = 0;
      end
      if (fv) begin
         if (full) m_drops++;
         else begin
            e = '{row_of(fpc), fo, fm};
            m_q.push_back(e);
         end
      end
      if (rq && stall) m_stalls++;
      hs_q.push_back('{cyc, stall, full, 1'b0});
   endtask

   // Monitor: compares whatever the DUT presents against the scoreboard.
   always @(negedge clk) begin
      hs_t h;
      tx_t t;
      if (cyc > 0) begin
         if (hs_q.size() == 0) begin
            checks++; errors++;
            $display("FAIL hs_queue at cycle %0d: got empty expected entry", cyc);
         end else begin
            h = hs_q.pop_front();
            chk("hs_cycle", cyc, h.cyc);
            chk("req_stall", o_req_stall, h.stall);
            chk("fb_full", o_fb_full, h.full);
            if (h.rst) begin
               chk("rst_index", o_tbl_index, 0);
               chk("rst_we", o_tbl_we, 0);
               chk("rst_en", o_tbl_en, 0);
            end
         end
         if (o_tbl_en === 1'b1) begin
            if (tx_q.size() == 0) begin
               checks++; errors++;
               $display("FAIL tbl_access at cycle %0d: got access expected none", cyc);
            end else begin
               t = tx_q.pop_front();
               chk("tbl_cycle", cyc, t.cyc);
               chk("tbl_we", o_tbl_we, t.we);
               chk("tbl_index", o_tbl_index, t.idx);
               if (t.we) begin
                  chk("tbl_outcome", o_tbl_outcome, t.outc);
                  chk("tbl_force", o_tbl_force, t.frc);
               end
            end
         end
      end
   end

   function automatic logic [31:0] rpc_r();
      return $urandom;
   endfunction

   task automatic run_until_phase(input int ph);
      int n = 0;
      while (m_phase != ph && n < 50) begin
         step(1, 1, rpc_r(), 0, 0, 0, 0);
         n++;
      end
      if (m_phase != ph) begin
         checks++; errors++;
         $display("FAIL wait_phase: got %0d expected %0d", m_phase, ph);
      end
   endtask

   initial begin
      repeat (3) step(0, 0, 0, 0, 0, 0, 0);
      // Lookups only
      for (int i = 0; i < 20; i++) step(1, 1, rpc_r(), 0, 0, 0, 0);
      // Single feedback, no lookups
      step(1, 0, 0, 1, 32'h0040_0010, 1, 1);
      repeat (4) step(1, 0, 0, 0, 0, 0, 0);
      // Continuous lookups with one feedback: forced update after the limit
      step(1, 1, rpc_r(), 1, rpc_r(), 0, 1);
      for (int i = 0; i < 14; i++) step(1, 1, rpc_r(), 0, 0, 0, 0);
      // Five back-to-back feedbacks while lookups starve the port
      for (int i = 0; i < 5; i++) step(1, 1, rpc_r(), 1, rpc_r(), i[0], i[1]);
      for (int i = 0; i < 40; i++) step(1, 1, rpc_r(), 0, 0, 0, 0);
      repeat (10) step(1, 0, 0, 0, 0, 0, 0);
      // Push during the write of the head with two entries queued
      step(1, 1, rpc_r(), 1, 32'h0000_0100, 1, 0);
      step(1, 1, rpc_r(), 1, 32'h0000_0200, 0, 1);
      run_until_phase(2);
      step(1, 1, rpc_r(), 1, 32'h0000_0300, 1, 1);
      repeat (10) step(1, 0, 0, 0, 0, 0, 0);
      // Reset during the row read with three entries queued
      for (int i = 0; i < 3; i++) step(1, 1, rpc_r(), 1, rpc_r(), 1, 0);
      run_until_phase(1);
      step(0, 1, rpc_r(), 0, 0, 0, 0);
      repeat (4) step(1, 0, 0, 0, 0, 0, 0);
      // Randomized traffic
      for (int i = 0; i < 3000; i++) begin
         step(($urandom_range(0, 499) != 0), ($urandom_range(0, 9) < 7), rpc_r(),
              ($urandom_range(0, 9) < 3), rpc_r(), $urandom_range(0, 1) != 0,
              $urandom_range(0, 1) != 0);
      end
      repeat (20) step(1, 0, 0, 0, 0, 0, 0);
      @(posedge clk); #1;
      chk("tx_queue_drained", tx_q.size(), 0);
      chk("model_fifo_drained", m_q.size(), 0);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
